// File: rtl/fifo_tx_arbiter_pkg.sv
// Shared definitions for the two-FIFO transmit arbiter: FSM state encoding and FIFO indices.
package fifo_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StSend   = 3'd2,
    StPop    = 3'd3,
    StSettle = 3'd4
  } arb_state_e;

  localparam logic Fifo0 = 1'b0;
  localparam logic Fifo1 = 1'b1;

endpackage

// File: rtl/fifo_tx_arbiter_select.sv
// Combinational next-grant choice for two requesters.
// ARB_FIXED_PRIORITY_EN: FIFO 0 always wins a tie; otherwise round-robin on burst_done.
module arb_rr2_select
  import fifo_tx_arbiter_pkg::*;
(
  input  logic empty0,
  input  logic empty1,
  input  logic grant,
  input  logic burst_done,
  output logic next_grant,
  output logic any_req
);

  always_comb begin
    any_req    = !empty0 || !empty1;
    next_grant = grant;
    if (!empty0 && !empty1) begin
`ifdef ARB_FIXED_PRIORITY_EN
      next_grant = Fifo0;
`else
      next_grant = burst_done ? ~grant : grant;
`endif
    end else if (!empty0) begin
      next_grant = Fifo0;
    end else if (!empty1) begin
      next_grant = Fifo1;
    end
  end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Drains two byte FIFOs onto one valid/ready transmitter in bursts of up to MAX_BURST bytes.
// Optional ARB_FIXED_PRIORITY_EN gives FIFO 0 strict priority (see arb_rr2_select).
module fifo_tx_arbiter
  import fifo_tx_arbiter_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int MAX_BURST       = 4,
  parameter int BURST_CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo0_data,
  input  logic             fifo0_empty,
  output logic             fifo0_read,
  input  logic [WIDTH-1:0] fifo1_data,
  input  logic             fifo1_empty,
  output logic             fifo1_read,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             grant,
  output logic             busy
);

  localparam logic [BURST_CNT_WIDTH-1:0] BurstMax = BURST_CNT_WIDTH'(MAX_BURST);

  arb_state_e                 state;
  logic [BURST_CNT_WIDTH-1:0] burst_cnt;
  logic                       burst_done;
  logic                       next_grant;
  logic                       any_req;

  // In IDLE a tie always goes to the FIFO that was not granted last.
  assign burst_done = (state == StIdle) || (burst_cnt >= BurstMax);
  assign busy       = (state != StIdle);

  arb_rr2_select u_select (
    .empty0     (fifo0_empty),
    .empty1     (fifo1_empty),
    .grant      (grant),
    .burst_done (burst_done),
    .next_grant (next_grant),
    .any_req    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      fifo0_read <= 1'b0;
      fifo1_read <= 1'b0;
      grant      <= Fifo1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (enable && any_req) begin
            grant     <= next_grant;
            burst_cnt <= '0;
            state     <= StLoad;
          end
        end
        StLoad: begin
          tx_data  <= (grant == Fifo0) ? fifo0_data : fifo1_data;
          tx_valid <= 1'b1;
          state    <= StSend;
        end
        StSend: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            fifo0_read <= (grant == Fifo0);
            fifo1_read <= (grant == Fifo1);
            if (burst_cnt < BurstMax) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
            state <= StPop;
          end
        end
        StPop: begin
          fifo0_read <= 1'b0;
          fifo1_read <= 1'b0;
          state      <= StSettle;
        end
        StSettle: begin
          if (!enable || !any_req) begin
            state <= StIdle;
          end else begin
            grant <= next_grant;
            // Restart the count on rotation or when an exhausted burst continues alone.
            if ((next_grant != grant) || burst_done) begin
              burst_cnt <= '0;
            end
            state <= StLoad;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Directed self-checking bench for fifo_tx_arbiter with behavioural FIFO models and a bus monitor.
module tb_fifo_tx_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         tx_ready = 1'b0;
  logic [W-1:0] fifo0_data, fifo1_data, tx_data;
  logic         fifo0_empty, fifo1_empty, fifo0_read, fifo1_read, tx_valid, grant, busy;

  logic [W-1:0] mem0 [32];
  logic [W-1:0] mem1 [32];
  logic [4:0]   wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;

  assign fifo0_data  = mem0[rp0];
  assign fifo1_data  = mem1[rp1];
  assign fifo0_empty = (wp0 == rp0);
  assign fifo1_empty = (wp1 == rp1);

  always #5 clk = ~clk;

  fifo_tx_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo0_data  (fifo0_data),
    .fifo0_empty (fifo0_empty),
    .fifo0_read  (fifo0_read),
    .fifo1_data  (fifo1_data),
    .fifo1_empty (fifo1_empty),
    .fifo1_read  (fifo1_read),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .busy        (busy)
  );

  // FIFO pointers advance on the read-pulse edge
  always @(posedge clk) begin
    if (fifo0_read) rp0 <= rp0 + 5'd1;
    if (fifo1_read) rp1 <= rp1 + 5'd1;
  end

  // Monitor: log handshakes and read-pulse statistics
  logic [W-1:0] log_d [64];
  logic         log_s [64];
  int           log_c [64];
  int n = 0, cyc = 0, r0 = 0, r1 = 0, overlap = 0, dbl = 0, orphan = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, hs_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) begin
      log_d[n] <= tx_data;
      log_s[n] <= grant;
      log_c[n] <= cyc;
      n        <= n + 1;
    end
    if (fifo0_read) r0 <= r0 + 1;
    if (fifo1_read) r1 <= r1 + 1;
    if (fifo0_read && fifo1_read) overlap <= overlap + 1;
    if ((fifo0_read && prev0) || (fifo1_read && prev1)) dbl <= dbl + 1;
    if ((fifo0_read || fifo1_read) && !hs_prev) orphan <= orphan + 1;
    prev0   <= fifo0_read;
    prev1   <= fifo1_read;
    hs_prev <= tx_valid && tx_ready;
  end

  int checks = 0, failures = 0;

  task automatic push0(input logic [W-1:0] d);
    mem0[wp0] = d;
    wp0 = wp0 + 5'd1;
  endtask

  task automatic push1(input logic [W-1:0] d);
    mem1[wp1] = d;
    wp1 = wp1 + 5'd1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input bit need_empty, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && (!need_empty || (fifo0_empty && fifo1_empty))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    int base, r0s;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, fifo0_read, fifo1_read, busy, grant, tx_data} !== {5'b00001, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b%b/%h exp=00001/00", tx_valid, fifo0_read,
               fifo1_read, busy, grant, tx_data);
    end
    rst_n = 1'b1;
    push0(8'h55);
    push1(8'h66);
    enable = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || grant !== 1'b0 || tx_data !== 8'h55) begin
      failures++;
      $display("FAIL first_pick ok=%0d grant=%b data=%h exp grant=0 data=55", ok, grant, tx_data);
    end
    r0s = r0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, fifo0_read, fifo1_read, busy, grant} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_mid_send got=%b%b%b%b%b exp=00001", tx_valid, fifo0_read, fifo1_read,
               busy, grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (r0 !== r0s || fifo0_empty !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_pop reads=%0d exp=%0d empty=%b exp=0", r0 - r0s, 0, fifo0_empty);
    end
    wait_valid(ok);
    checks++;
    if (!ok || grant !== 1'b0 || tx_data !== 8'h55) begin
      failures++;
      $display("FAIL pick_after_reset ok=%0d grant=%b data=%h exp 0/55", ok, grant, tx_data);
    end
    base = n;
    tx_ready = 1'b1;
    wait_idle(1'b1, ok);
    checks++;
    if (!ok || n - base !== 2 || log_d[base] !== 8'h55 || log_d[base+1] !== 8'h66) begin
      failures++;
      $display("FAIL reset_drain ok=%0d sent=%0d exp=2", ok, n - base);
    end
  endtask

  task automatic test_single_fifo();
    bit ok;
    int base, r0s, r1s;
    logic [W-1:0] exp_d [3];
    exp_d = '{8'hA1, 8'hA2, 8'hA3};
    @(posedge clk);
    #1;
    base = n;
    r0s  = r0;
    r1s  = r1;
    push0(8'hA1);
    push0(8'hA2);
    push0(8'hA3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early tx_valid=%b exp=0", tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
      failures++;
      $display("FAIL latency_2edges tx_valid=%b data=%h exp 1/a1", tx_valid, tx_data);
    end
    wait_idle(1'b1, ok);
    checks++;
    if (!ok || n - base !== 3) begin
      failures++;
      $display("FAIL single_count ok=%0d sent=%0d exp=3", ok, n - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_d[base+i] !== exp_d[i] || log_s[base+i] !== 1'b0) begin
        failures++;
        $display("FAIL single_byte%0d got=%h/%b exp=%h/0", i, log_d[base+i], log_s[base+i],
                 exp_d[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (log_c[base+i] - log_c[base+i-1] !== 4) begin
        failures++;
        $display("FAIL single_spacing%0d got=%0d exp=4", i, log_c[base+i] - log_c[base+i-1]);
      end
    end
    checks++;
    if (r0 - r0s !== 3 || r1 - r1s !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_reads r0=%0d r1=%0d busy=%b exp 3/0/0", r0 - r0s, r1 - r1s, busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int base;
    logic [W-1:0] exp_d [12];
    logic         exp_s [12];
`ifdef ARB_FIXED_PRIORITY_EN
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    exp_s = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
`else
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h14, 8'h15, 8'h24, 8'h25};
    exp_s = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`endif
    do_reset();
    base = n;
    for (int i = 0; i < 6; i++) begin
      push0(8'h10 + 8'(i));
      push1(8'h20 + 8'(i));
    end
    wait_idle(1'b1, ok);
    checks++;
    if (!ok || n - base !== 12) begin
      failures++;
      $display("FAIL rr_count ok=%0d sent=%0d exp=12", ok, n - base);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_d[base+i] !== exp_d[i] || log_s[base+i] !== exp_s[i]) begin
        failures++;
        $display("FAIL rr_order%0d got=%h/%b exp=%h/%b", i, log_d[base+i], log_s[base+i],
                 exp_d[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base, r0s;
    tx_ready = 1'b0;
    base = n;
    r0s  = r0;
    push0(8'h77);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_valid_timeout tx_valid=%b exp=1", tx_valid);
    end
    mem0[rp0] = 8'h99;  // head changes while in SEND; must not reach tx_data
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h77 || r0 !== r0s) begin
        failures++;
        $display("FAIL bp_hold%0d valid=%b data=%h reads=%0d exp 1/77/0", i, tx_valid, tx_data,
                 r0 - r0s);
      end
    end
    tx_ready = 1'b1;
    wait_idle(1'b1, ok);
    checks++;
    if (!ok || r0 - r0s !== 1 || n - base !== 1 || log_d[base] !== 8'h77) begin
      failures++;
      $display("FAIL bp_release reads=%0d sent=%0d exp 1/1", r0 - r0s, n - base);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int base, r0s;
    tx_ready = 1'b0;
    base = n;
    r0s  = r0;
    for (int i = 0; i < 5; i++) push0(8'h30 + 8'(i));
    wait_valid(ok);
    enable   = 1'b0;
    tx_ready = 1'b1;
    wait_idle(1'b0, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b0 || r0 - r0s !== 1 || n - base !== 1 || log_d[base] !== 8'h30) begin
      failures++;
      $display("FAIL en_drop busy=%b reads=%0d sent=%0d exp 0/1/1", busy, r0 - r0s, n - base);
    end
    checks++;
    if (5'(wp0 - rp0) !== 5'd4) begin
      failures++;
      $display("FAIL en_drop_left got=%0d exp=4", 5'(wp0 - rp0));
    end
    enable = 1'b1;
    wait_idle(1'b1, ok);
    checks++;
    if (!ok || n - base !== 5) begin
      failures++;
      $display("FAIL en_resume sent=%0d exp=5", n - base);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (log_d[base+i] !== 8'h30 + 8'(i)) begin
        failures++;
        $display("FAIL en_resume_byte%0d got=%h exp=%h", i, log_d[base+i], 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (overlap !== 0 || dbl !== 0 || orphan !== 0) begin
      failures++;
      $display("FAIL pulse_rules overlap=%0d double=%0d orphan=%0d exp 0/0/0", overlap, dbl,
               orphan);
    end
  endtask

  initial begin
    test_reset();
    test_single_fifo();
    test_round_robin();
    test_backpressure();
    test_enable_drop();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
